// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and defaults for the bit-serial subtractor
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// rtl/serial_subtractor_full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, valid/ready on both sides
module serial_subtractor
  import sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             borrow_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             sum;
  logic             c_next;
  logic [WIDTH-1:0] res_d;

  // Subtraction as A + ~B + ~Bin through one adder cell
  full_adder u_fa (
    .a_i (a_sh_q[0]),
    .b_i (~b_sh_q[0]),
    .c_i (carry_q),
    .s_o (sum),
    .c_o (c_next)
  );

  assign res_d = {sum, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            carry_q <= ~Bin;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q   <= res_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= c_next;
          cnt_q   <= cnt_q + CNT_W'(1);
          // carry_q here is the carry into the MSB, needed for signed overflow
          if (cnt_q == LAST) begin
            diff_q      <= res_d;
            borrow_q    <= ~c_next;
            ovf_q       <= carry_q ^ c_next;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Independent reference: {ovf, borrow, diff} from integer arithmetic
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
    int ua, ub, sa, sb, sr;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    d  = W'(ua - ub - int'(bin));
    bo = (ua < ub + int'(bin));
    sr = sa - sb - int'(bin);
    ov = (sr > 7) || (sr < -8);
    return {ov, bo, d};
  endfunction

  // Issues one operation from IDLE and waits for out_valid; edges = -1 on timeout
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                output int edges);
    in_valid = 1'b1;
    A = a;
    B = b;
    Bin = bin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic release_result(input int stall);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b diff=%h borrow=%b ovf=%b, want all 0",
               out_valid, diff, borrow, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [5] = '{4'h7, 4'h3, 4'h0, 4'h8, 4'h7};
    logic [W-1:0] vb [5] = '{4'h3, 4'h7, 4'h0, 4'h1, 4'hF};
    logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ed [5] = '{4'h4, 4'hC, 4'hF, 4'h7, 4'h8};
    logic         eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int edges;
    for (int i = 0; i < 5; i++) begin
      start_and_wait(va[i], vb[i], vc[i], edges);
      checks++;
      if (edges !== W) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d edges want %0d", i, edges, W);
      end
      checks++;
      if (diff !== ed[i] || borrow !== eb[i] || ovf !== eo[i]) begin
        errors++;
        $display("FAIL vector[%0d]: got diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                 i, diff, borrow, ovf, ed[i], eb[i], eo[i]);
      end
      release_result(0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL release[%0d]: got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    int edges;
    int bad = 0;
    start_and_wait(4'h3, 4'h7, 1'b0, edges);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || diff !== 4'hC || borrow !== 1'b1 || ovf !== 1'b0 ||
          in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (edges < 0 || bad != 0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles (edges=%0d) want 0", bad, edges);
    end
    release_result(0);
  endtask

  task automatic test_busy_ignore;
    int edges = 0;
    int spurious = 0;
    in_valid = 1'b1;
    A = 4'h9;
    B = 4'h2;
    Bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    A = 4'h1;
    B = 4'h1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checks++;
    if (!out_valid || diff !== 4'h7 || borrow !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL busy_result: got valid=%b diff=%h borrow=%b ovf=%b want 1/7/0/1",
               out_valid, diff, borrow, ovf);
    end
    release_result(0);
    repeat (8) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL busy_no_second_op: got %0d busy cycles want 0", spurious);
    end
  endtask

  task automatic test_reset_mid_shift;
    int spurious = 0;
    in_valid = 1'b1;
    A = 4'h5;
    B = 4'h2;
    Bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || borrow !== 1'b0 ||
        ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got ready=%b valid=%b diff=%h borrow=%b ovf=%b want 1/0/0/0/0",
               in_ready, out_valid, diff, borrow, ovf);
    end
    repeat (8) begin
      if (out_valid !== 1'b0) spurious++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL reset_abort_valid: got %0d valid cycles want 0", spurious);
    end
  endtask

  task automatic test_back_to_back;
    int edges;
    start_and_wait(4'h5, 4'h2, 1'b0, edges);
    checks++;
    if (edges !== W || diff !== 4'h3 || borrow !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got edges=%0d diff=%h borrow=%b ovf=%b want %0d/3/0/0",
               edges, diff, borrow, ovf, W);
    end
    release_result(0);
    start_and_wait(4'h2, 4'h5, 1'b0, edges);
    checks++;
    if (edges !== W || diff !== 4'hD || borrow !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got edges=%0d diff=%h borrow=%b ovf=%b want %0d/d/1/0",
               edges, diff, borrow, ovf, W);
    end
    release_result(0);
  endtask

  task automatic test_random;
    int edges;
    int bad = 0;
    logic [W-1:0] a, b;
    logic c;
    logic [W+1:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      exp_v = ref_sub(a, b, c);
      if (in_ready !== 1'b1) bad++;
      out_ready = 1'($urandom);
      start_and_wait(a, b, c, edges);
      out_ready = 1'b0;
      checks++;
      if (edges !== W || {ovf, borrow, diff} !== exp_v) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d] %h-%h-%b: got edges=%0d diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                   i, a, b, c, edges, diff, borrow, ovf, exp_v[W-1:0], exp_v[W], exp_v[W+1]);
      end
      if (edges < 0) begin
        $display("FAIL random_timeout: no out_valid within 50 cycles");
        break;
      end
      release_result($urandom_range(0, 3));
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_summary: got %0d bad operations want 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_busy_ignore;
    test_reset_mid_shift;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; the inverse operation to the team's ripple-carry adder.
- Computes DIFF = A - B - Bin one bit per cycle, LSB first, using a single full-adder cell as A + ~B + ~Bin.
- Valid/ready handshake on both input and output; intended for area-constrained datapaths where a full-width subtractor is not justified.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands A, B, Bin valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH
- borrow  output  1  borrow out; 1 when unsigned A < B + Bin
- ovf  output  1  signed overflow; carry into MSB XOR carry out of MSB

Behaviour:
- Reset: sampled on the rising clk edge while rst_n=0; reset dominates all other inputs.
  - State goes to IDLE.
  - diff, borrow, ovf, out_valid and the internal shift registers/counter all clear to 0.
  - in_ready=1 from the first cycle after reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1, capture A into a_sh, B into b_sh, set carry=~Bin, clear cnt, go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle: {c_next, s} = a_sh[0] + ~b_sh[0] + carry.
  - Shift s into the MSB of the result register; shift a_sh and b_sh right by 1; carry <= c_next; cnt <= cnt+1.
  - On the WIDTH-1 step, additionally latch the incoming carry (the carry into the MSB) for ovf.
  - When cnt reaches WIDTH-1 after the step, go to DONE.
- DONE:
  - out_valid=1; diff, borrow=~carry and ovf are held stable.
  - On out_ready=1 go to IDLE; out_valid drops on the next cycle.
  - Without out_ready, hold indefinitely. Outputs must not change while out_valid=1 and out_ready=0.
- Latency:
  - The accept edge is edge 0. SHIFT occupies edges 1..WIDTH.
  - out_valid is high in the cycle after edge WIDTH.
  - Throughput is one operation per WIDTH+2 cycles minimum (no IDLE bypass).
- in_ready is a pure decode of state==IDLE (combinational from registered state). All other outputs are registered.
- Boundary conditions:
  - in_valid while busy (SHIFT/DONE): ignored; operands are not captured and no queueing occurs.
  - A/B/Bin changing after the accept edge: no effect on the result.
  - out_ready high outside DONE: no effect.
  - Reset mid-SHIFT or in DONE: the operation is aborted, outputs clear, and no out_valid is produced for it.
  - Bin=1 with A=B: diff all-ones, borrow=1.
  - WIDTH-bit wrap: diff is modulo 2^WIDTH; the sign interpretation is left to the consumer via ovf.
- No combinational path from any input to any output except in_ready, which depends on state only.

Decomposition:
- Package sub_pkg:
  - state enum (IDLE, SHIFT, DONE), 2-bit encoding.
  - localparam DEFAULT_WIDTH = 4.
- Sub-module: existing full_adder, instantiated once as the bit-serial cell (inputs a_sh[0], ~b_sh[0], carry; outputs sum, c_next).
- No other sub-modules.

Test Plan:
- WIDTH=4, A=7, B=3, Bin=0, out_ready=1 -> out_valid exactly 4 edges after accept; diff=4, borrow=0, ovf=0.
- A=3, B=7, Bin=0 -> diff=0xC, borrow=1, ovf=0; A=0, B=0, Bin=1 -> diff=0xF, borrow=1, ovf=0.
- A=0x8, B=0x1, Bin=0 -> diff=0x7, borrow=0, ovf=1; A=0x7, B=0xF -> diff=0x8, borrow=1, ovf=1.
- Backpressure and busy stimulus:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid, diff, borrow and ovf remain stable; in_ready=0 throughout.
  - Pulse in_valid with new operands during SHIFT -> result unchanged and the second operation is not started.
- Reset and back-to-back:
  - Assert rst_n=0 on the 2nd SHIFT cycle -> next cycle state IDLE, all outputs 0, in_ready=1, no out_valid for the aborted operation.
  - Issue two back-to-back operations, 5-2 then 2-5 -> 3/borrow0 followed by 0xD/borrow1.
- Random regression: 1000 random A, B, Bin with random out_ready stalls, checked against a reference model of (A - B - Bin) mod 16, borrow, ovf.
